char_grid_feature_scan: RTL

- Parametrised successor to the fixed 3x3 character feature scanner in the plate-recognition video path (OV5640 -> SDRAM -> LCD).
- Divides a character bounding box into a GRID_ROWS x GRID_COLS grid and counts thresholded foreground pixels per cell within each frame.
- At end of frame, snapshots the counts and produces a per-cell feature bit vector with a one-cycle valid strobe for the downstream digit classifier.
- Video passes through with one register stage for overlay.

---
 rtl/char_grid_feature_scan.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/char_grid_feature_scan.sv
// Splits a character bounding box into a GRID_ROWS x GRID_COLS grid, counts foreground pixels per cell
// and snapshots counts/feature bits at each i_vs falling edge. Optional macro: STABLE_FILTER_EN.
module char_grid_feature_scan #(
  parameter int COORD_W       = 12,
  parameter int GRID_ROWS     = 3,
  parameter int GRID_COLS     = 3,
  parameter int CNT_W         = 12,
  parameter int STABLE_FRAMES = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_hs,
  input  logic                                 i_vs,
  input  logic                                 i_de,
  input  logic [COORD_W-1:0]                   i_x,
  input  logic [COORD_W-1:0]                   i_y,
  input  logic [23:0]                          i_data,
  input  logic                                 i_th,
  input  logic [COORD_W-1:0]                   char_left,
  input  logic [COORD_W-1:0]                   char_right,
  input  logic [COORD_W-1:0]                   char_up,
  input  logic [COORD_W-1:0]                   char_down,
  input  logic [COORD_W-1:0]                   cell_w,
  input  logic [COORD_W-1:0]                   cell_h,
  input  logic [CNT_W-1:0]                     hit_th,
  output logic [GRID_ROWS*GRID_COLS-1:0]       feature_code,
  output logic [GRID_ROWS*GRID_COLS*CNT_W-1:0] cell_count,
  output logic                                 code_valid,
  output logic                                 bbox_err,
  output logic [23:0]                          o_data,
  output logic [COORD_W-1:0]                   o_x,
  output logic [COORD_W-1:0]                   o_y,
  output logic                                 o_hs,
  output logic                                 o_vs,
  output logic                                 o_de
);

  localparam int NCELL = GRID_ROWS * GRID_COLS;
  // Extra headroom so char_left + GRID_COLS*cell_w never wraps.
  localparam int EW    = COORD_W + 4;

  logic [NCELL-1:0][CNT_W-1:0] cnt_q, cnt_d, cell_count_q;
  logic [NCELL-1:0]            code_s, feature_code_q;
  logic [GRID_COLS-1:0]        col_hit_s;
  logic [GRID_ROWS-1:0]        row_hit_s;
  logic                        box_invalid_s, count_en_s, snap_s, upd_s;
  logic                        low_seen_q, err_frame_q, code_valid_q, bbox_err_q;
  logic [23:0]                 o_data_q;
  logic [COORD_W-1:0]          o_x_q, o_y_q;
  logic                        o_hs_q, o_vs_q, o_de_q;

  assign box_invalid_s = (char_right < char_left) || (char_down < char_up) ||
                         (cell_w == {COORD_W{1'b0}}) || (cell_h == {COORD_W{1'b0}});
  assign count_en_s    = i_vs && i_de && i_th && !box_invalid_s;
  // A snapshot needs a low i_vs seen since reset, so a frame cut by reset is never reported.
  assign snap_s        = o_vs_q && !i_vs && low_seen_q;

  for (genvar gc = 0; gc < GRID_COLS; gc++) begin : g_col
    logic [EW-1:0] lo_s, hi_s;
    assign lo_s = EW'(char_left) + EW'(gc) * EW'(cell_w);
    if (gc == GRID_COLS - 1) begin : g_last
      assign hi_s = EW'(char_right);
    end else begin : g_mid
      assign hi_s = lo_s + EW'(cell_w) - EW'(1'b1);
    end
    assign col_hit_s[gc] = (EW'(i_x) >= lo_s) && (EW'(i_x) <= hi_s) && (i_x <= char_right);
  end

  for (genvar gr = 0; gr < GRID_ROWS; gr++) begin : g_row
    logic [EW-1:0] lo_s, hi_s;
    assign lo_s = EW'(char_up) + EW'(gr) * EW'(cell_h);
    if (gr == GRID_ROWS - 1) begin : g_last
      assign hi_s = EW'(char_down);
    end else begin : g_mid
      assign hi_s = lo_s + EW'(cell_h) - EW'(1'b1);
    end
    assign row_hit_s[gr] = (EW'(i_y) >= lo_s) && (EW'(i_y) <= hi_s) && (i_y <= char_down);
  end

  // Per-cell saturating counters, cleared whenever i_vs is low.
  always_comb begin
    cnt_d = cnt_q;
    for (int r = 0; r < GRID_ROWS; r++) begin
      for (int c = 0; c < GRID_COLS; c++) begin
        if (!i_vs) begin
          cnt_d[r*GRID_COLS+c] = {CNT_W{1'b0}};
        end else if (count_en_s && row_hit_s[r] && col_hit_s[c] &&
                     (cnt_q[r*GRID_COLS+c] != {CNT_W{1'b1}})) begin
          cnt_d[r*GRID_COLS+c] = cnt_q[r*GRID_COLS+c] + CNT_W'(1'b1);
        end else begin
          cnt_d[r*GRID_COLS+c] = cnt_q[r*GRID_COLS+c];
        end
      end
    end
  end

  // Feature bits from the live (pre-clear) counts.
  always_comb begin
    code_s = {NCELL{1'b0}};
    for (int k = 0; k < NCELL; k++) begin
      code_s[k] = (cnt_q[k] >= hit_th);
    end
  end

`ifdef STABLE_FILTER_EN
  localparam int SW = $clog2(STABLE_FRAMES + 1) + 1;
  logic [SW-1:0]    stab_q, stab_d;
  logic [NCELL-1:0] prev_code_q;

  // Run length of identical snapshot codes, saturating at STABLE_FRAMES.
  always_comb begin
    stab_d = stab_q;
    if (code_s == prev_code_q) begin
      if (stab_q < SW'(STABLE_FRAMES)) begin
        stab_d = stab_q + SW'(1'b1);
      end else begin
        stab_d = stab_q;
      end
    end else begin
      stab_d = SW'(1'b1);
    end
    upd_s = (stab_d >= SW'(STABLE_FRAMES));
  end

  // Stability history register, advanced once per snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_q      <= {SW{1'b0}};
      prev_code_q <= {NCELL{1'b0}};
    end else if (snap_s) begin
      stab_q      <= stab_d;
      prev_code_q <= code_s;
    end else begin
      stab_q      <= stab_q;
      prev_code_q <= prev_code_q;
    end
  end
`else
  assign upd_s = 1'b1;
`endif

  // Counters, frame tracking, snapshots and the one-stage video pass-through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= {(NCELL*CNT_W){1'b0}};
      cell_count_q   <= {(NCELL*CNT_W){1'b0}};
      feature_code_q <= {NCELL{1'b0}};
      low_seen_q     <= 1'b0;
      err_frame_q    <= 1'b0;
      code_valid_q   <= 1'b0;
      bbox_err_q     <= 1'b0;
      o_data_q       <= 24'h000000;
      o_x_q          <= {COORD_W{1'b0}};
      o_y_q          <= {COORD_W{1'b0}};
      o_hs_q         <= 1'b0;
      o_vs_q         <= 1'b0;
      o_de_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      low_seen_q   <= low_seen_q || !i_vs;
      err_frame_q  <= i_vs ? (err_frame_q || box_invalid_s) : 1'b0;
      code_valid_q <= snap_s;
      if (snap_s) begin
        cell_count_q   <= cnt_q;
        bbox_err_q     <= err_frame_q || box_invalid_s;
        feature_code_q <= upd_s ? code_s : feature_code_q;
      end else begin
        cell_count_q   <= cell_count_q;
        bbox_err_q     <= bbox_err_q;
        feature_code_q <= feature_code_q;
      end
      o_data_q <= i_data;
      o_x_q    <= i_x;
      o_y_q    <= i_y;
      o_hs_q   <= i_hs;
      o_vs_q   <= i_vs;
      o_de_q   <= i_de;
    end
  end

  assign feature_code = feature_code_q;
  assign cell_count   = cell_count_q;
  assign code_valid   = code_valid_q;
  assign bbox_err     = bbox_err_q;
  assign o_data       = o_data_q;
  assign o_x          = o_x_q;
  assign o_y          = o_y_q;
  assign o_hs         = o_hs_q;
  assign o_vs         = o_vs_q;
  assign o_de         = o_de_q;

endmodule
